// File: rtl/wpm_calc.sv
// Words-per-minute engine: saturating word counter, BCD time to seconds,
// multicycle restoring divide of words*6000 by seconds, then double-dabble to BCD.
module wpm_calc #(
    parameter int WORD_W = 11,
    parameter int NUM_W  = WORD_W + 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_done,
    input  logic              game_over,
    input  logic [3:0]        minutes,
    input  logic [3:0]        sec_high,
    input  logic [3:0]        sec_low,
    output logic [WORD_W-1:0] total_words,
    output logic [16:0]       wpm_x100,
    output logic [19:0]       wpm_bcd,
    output logic              wpm_valid,
    output logic              busy
);

    localparam int CNT_W = ($clog2(NUM_W) > 5) ? $clog2(NUM_W) : 5;
    localparam logic [16:0] WPM_MAX = 17'd99999;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, CONV, DONE} state_t;

    state_t            state, state_next;
    logic [9:0]        sec_sum, sec_r, snap_sec, den, rem;
    logic [WORD_W-1:0] snap_words;
    logic [NUM_W-1:0]  num, quo;
    logic [CNT_W-1:0]  cnt;
    logic [16:0]       bin, bin_next, dd_bin, sat_val, x100_hold;
    logic [19:0]       bcd, bcd_next, dd_bcd, dd_adj;
    logic [10:0]       rem_sh;
    logic              div_ge, trigger;

    always_comb begin
        sec_sum = 10'(minutes) * 10'd60 + 10'(sec_high) * 10'd10 + 10'(sec_low);
        trigger = (state == IDLE) && !game_over &&
                  ((total_words != snap_words) || (sec_r != snap_sec));
        rem_sh  = {rem, num[NUM_W-1]};
        div_ge  = rem_sh >= {1'b0, den};
    end

    // A zero denominator would yield an all-ones quotient, so it is forced to 0.
    always_comb begin
        if (den == '0)
            sat_val = '0;
        else if (quo > NUM_W'(WPM_MAX))
            sat_val = WPM_MAX;
        else
            sat_val = quo[16:0];
    end

    // First conversion cycle seeds the shifter straight from the saturated quotient.
    always_comb begin
        dd_bin = (cnt == '0) ? sat_val : bin;
        dd_bcd = (cnt == '0) ? '0 : bcd;
        dd_adj = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            dd_adj[4*i +: 4] = (dd_bcd[4*i +: 4] >= 4'd5) ? dd_bcd[4*i +: 4] + 4'd3
                                                           : dd_bcd[4*i +: 4];
        end
        {bcd_next, bin_next} = {dd_adj, dd_bin} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = LOAD;
            LOAD:    state_next = DIV;
            DIV:     if (cnt == CNT_W'(NUM_W - 1)) state_next = CONV;
            CONV:    if (cnt == CNT_W'(16)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        wpm_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_words <= '0;
            sec_r       <= '0;
            snap_words  <= '0;
            snap_sec    <= '0;
            num         <= '0;
            den         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            bin         <= '0;
            bcd         <= '0;
            x100_hold   <= '0;
            wpm_x100    <= '0;
            wpm_bcd     <= '0;
        end else begin
            if (word_done && !game_over && (total_words != '1))
                total_words <= total_words + WORD_W'(1);
            sec_r <= sec_sum;
            case (state)
                LOAD: begin
                    snap_words <= total_words;
                    snap_sec   <= sec_r;
                    num        <= NUM_W'(total_words) * NUM_W'(6000);
                    den        <= sec_r;
                    rem        <= '0;
                    quo        <= '0;
                    cnt        <= '0;
                end
                DIV: begin
                    num <= num << 1;
                    rem <= div_ge ? 10'(rem_sh - {1'b0, den}) : rem_sh[9:0];
                    quo <= {quo[NUM_W-2:0], div_ge};
                    cnt <= (cnt == CNT_W'(NUM_W - 1)) ? '0 : cnt + CNT_W'(1);
                end
                CONV: begin
                    bin <= bin_next;
                    bcd <= bcd_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == '0)
                        x100_hold <= sat_val;
                    if (cnt == CNT_W'(16)) begin
                        wpm_x100 <= x100_hold;
                        wpm_bcd  <= bcd_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wpm_calc.md
Name: wpm_calc

Overview:
Sequential words-per-minute engine that sits downstream of the stopwatch and the player-activity block. It counts completed-word pulses and converts the stopwatch BCD time to whole seconds. It computes WPM×100 with an iterative restoring divider, then converts the result to BCD digits for the VGA/score display. It replaces the single-cycle divide in the top level with a fixed-latency multicycle datapath.

Parameters:
WORD_W, 11, width of the word counter; the counter saturates at 2^WORD_W-1.
NUM_W, WORD_W+13, numerator width (words×6000); this is also the number of divider iterations.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
word_done  in  1  one-cycle pulse per completed word
game_over  in  1  level; freezes counting and new computations
minutes  in  4  stopwatch BCD minutes, 0-9
sec_high  in  4  stopwatch BCD tens of seconds, 0-5
sec_low  in  4  stopwatch BCD seconds, 0-9
total_words  out  WORD_W  saturating count of word_done pulses
wpm_x100  out  17  WPM×100 in binary, saturated to 99999
wpm_bcd  out  20  packed BCD: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:4] tenths, [3:0] hundredths
wpm_valid  out  1  one-cycle pulse when wpm_x100 and wpm_bcd update
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-divide):
  - all outputs and internal registers are 0; state is IDLE.
- Word counter:
  - increments by 1 on each clock where word_done=1 and game_over=0.
  - holds at 2^WORD_W-1.
  - counts during busy.
- Seconds:
  - registered sec_r = minutes×60 + sec_high×10 + sec_low, 10 bits, maximum 599.
  - one-cycle lag from the inputs; inputs are guaranteed valid BCD.
- Snapshot registers snap_words and snap_sec are captured in LOAD.
- Trigger: in IDLE, game_over=0 and (total_words≠snap_words or sec_r≠snap_sec).
  - Updates that arrive while busy are not lost: on return to IDLE the compare fires again if the values moved.
- FSM, with k = the IDLE cycle in which the trigger is seen:
  - IDLE -> LOAD on trigger; otherwise stays in IDLE.
  - LOAD (cycle k+1): capture snapshots; numerator N = snap_words×6000 (NUM_W bits); denominator D = snap_sec; clear remainder.
  - DIV (cycles k+2 .. k+1+NUM_W): one restoring-division quotient bit per cycle, MSB first.
  - CONV (17 cycles): if D=0 the quotient is forced to 0; otherwise it saturates at 99999; then double-dabble to 5 BCD digits.
  - DONE (cycle k+NUM_W+19, i.e. k+43 at the defaults): wpm_x100 and wpm_bcd are registered; wpm_valid=1 for this cycle only; next state is IDLE.
- Outputs hold their last value between DONE cycles.
- game_over=1:
  - blocks new triggers and word counting.
  - a computation already in flight completes normally.
- Arithmetic:
  - integer division truncates toward zero (e.g. 933.33 -> 93333? no: 42000/45 = 933 -> "009.33").
  - no rounding.
- wpm_valid and busy are never both low while the state is not IDLE.

Test Plan:
1. Assert reset mid-DIV -> on the same edge window all outputs read 0, busy=0, state IDLE; after release, no wpm_valid until a new trigger.
2. 10 word_done pulses, time 1:00 -> wpm_valid exactly 43 cycles after the trigger IDLE cycle; wpm_x100=1000, wpm_bcd=0x01000.
3. 7 words, time 0:45 -> wpm_x100=933, wpm_bcd=0x00933.
4. 5 words, time 0:00 -> wpm_x100=0, wpm_bcd=0x00000, same 43-cycle latency.
5. Force total_words=2047 (2048+ pulses), time 0:01:
   - total_words stays 2047.
   - wpm_x100=99999, wpm_bcd=0x99999.
6. word_done pulse during DIV, then game_over=1 after the next DONE:
   - a second computation starts automatically using the new count.
   - after game_over, further pulses and time changes give no count change and no wpm_valid.
